// File: rtl/pattern_detector_cfg_if.sv
// Serial stream, match and configuration signals of pattern_detector_cfg.
// The match_cnt signal exists only when MATCH_COUNT_EN is defined.
interface pattern_detector_cfg_if #(
    parameter int unsigned MAX_LEN = 8
`ifdef MATCH_COUNT_EN
    ,
    parameter int unsigned CNT_W   = 16
`endif
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic               en;
    logic               din;
    logic               overlap;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               F;
    logic               cfg_err;
`ifdef MATCH_COUNT_EN
    logic [CNT_W-1:0]   match_cnt;
`endif

    // Stream / configuration source side
    modport master (
        output en, din, overlap, cfg_load, cfg_pat, cfg_len,
        input  F, cfg_err
`ifdef MATCH_COUNT_EN
        ,
        input  match_cnt
`endif
    );

    // Detector side
    modport slave (
        input  en, din, overlap, cfg_load, cfg_pat, cfg_len,
        output F, cfg_err
`ifdef MATCH_COUNT_EN
        ,
        output match_cnt
`endif
    );
endinterface

// File: rtl/pattern_detector_cfg.sv
// Runtime-configurable serial bit-pattern detector with registered match pulse F.
// Optional feature macro MATCH_COUNT_EN adds a saturating match counter (match_cnt).
module pattern_detector_cfg #(
    parameter int unsigned        MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(8'b1001),
    parameter int unsigned        DEFAULT_LEN = 4
`ifdef MATCH_COUNT_EN
    ,
    parameter int unsigned        CNT_W       = 16
`endif
) (
    input  logic                   clock,
    input  logic                   reset,
    pattern_detector_cfg_if.slave  bus
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    localparam logic [MAX_LEN:0] ONE_W = (MAX_LEN + 1)'(1);

    logic [MAX_LEN-1:0] hist_q, hist_nxt;
    logic [LEN_W-1:0]   fill_q, fill_nxt;
    logic [MAX_LEN-1:0] pat_q,  pat_nxt;
    logic [LEN_W-1:0]   len_q,  len_nxt;
    logic               f_q,    f_nxt;
    logic               err_q,  err_nxt;
`ifdef MATCH_COUNT_EN
    logic [CNT_W-1:0]   cnt_q,  cnt_nxt;
`endif

    logic [0:0]         state_c;
    logic [MAX_LEN-1:0] hist_shift_c;
    logic [MAX_LEN-1:0] mask_c;
    logic [LEN_W-1:0]   fill_inc_c;
    logic               match_c;
    logic               cfg_ok_c;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEFAULT_PAT;
            len_q  <= LEN_W'(DEFAULT_LEN);
            f_q    <= 1'b0;
            err_q  <= 1'b0;
`ifdef MATCH_COUNT_EN
            cnt_q  <= '0;
`endif
        end else begin
            hist_q <= hist_nxt;
            fill_q <= fill_nxt;
            pat_q  <= pat_nxt;
            len_q  <= len_nxt;
            f_q    <= f_nxt;
            err_q  <= err_nxt;
`ifdef MATCH_COUNT_EN
            cnt_q  <= cnt_nxt;
`endif
        end
    end

    // Next-state logic: cfg_load has priority over the serial stream
    always_comb begin
        hist_nxt = hist_q;
        fill_nxt = fill_q;
        pat_nxt  = pat_q;
        len_nxt  = len_q;
        f_nxt    = 1'b0;
        err_nxt  = err_q;
`ifdef MATCH_COUNT_EN
        cnt_nxt  = cnt_q;
`endif

        state_c      = (fill_q == len_q) ? ST_ARMED : ST_FILL;
        hist_shift_c = {hist_q[MAX_LEN-2:0], bus.din};
        fill_inc_c   = (state_c == ST_ARMED) ? len_q : LEN_W'(fill_q + 1'b1);
        // Only the low len bits of the history take part in the compare
        mask_c       = MAX_LEN'((ONE_W << len_q) - ONE_W);
        match_c      = bus.en && (fill_inc_c == len_q) &&
                       (((hist_shift_c ^ pat_q) & mask_c) == '0);
        cfg_ok_c     = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));

        if (bus.cfg_load && cfg_ok_c) begin
            pat_nxt  = bus.cfg_pat;
            len_nxt  = bus.cfg_len;
            hist_nxt = '0;
            fill_nxt = '0;
            err_nxt  = 1'b0;
`ifdef MATCH_COUNT_EN
            cnt_nxt  = '0;
`endif
        end else begin
            if (bus.cfg_load) begin
                err_nxt = 1'b1;
            end
            if (bus.en) begin
                hist_nxt = hist_shift_c;
                fill_nxt = (match_c && !bus.overlap) ? '0 : fill_inc_c;
                f_nxt    = match_c;
`ifdef MATCH_COUNT_EN
                if (match_c && (cnt_q != '1)) begin
                    cnt_nxt = CNT_W'(cnt_q + 1'b1);
                end
`endif
            end
        end
    end

    assign bus.F         = f_q;
    assign bus.cfg_err   = err_q;
`ifdef MATCH_COUNT_EN
    assign bus.match_cnt = cnt_q;
`endif

endmodule
